// File: rtl/seq_gen_pkg.sv
// Shared state encoding and default widths for the serial pattern generator.
package seq_gen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable pattern register with a bit-index counter that walks MSB to LSB and
// wraps back to the MSB, so repetitions follow each other without a gap.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pat_in,
    output logic             bit_cur,
    output logic             next_bit,
    output logic             last_bit
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            pat_q <= pat_in;
            idx_q <= IDX_TOP;
        end else if (shift) begin
            idx_q <= last_bit ? IDX_TOP : idx_q - IDX_W'(1);
        end
    end

    // next_bit is the bit that will be on the line after the current one.
    assign last_bit = (idx_q == '0);
    assign bit_cur  = pat_q[idx_q];
    assign next_bit = last_bit ? pat_q[PAT_W-1] : pat_q[idx_q - IDX_W'(1)];

endmodule

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated
// rep_in times. Define SEQ_GEN_PARITY_EN to append an even-parity bit per repetition.
module seq_gen_serial
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic             stop,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] rep_cnt;
    logic             par_bit;
    logic             par_phase;
    logic             sr_load;
    logic             sr_shift;
    logic             bit_cur;
    logic             next_bit;
    logic             last_bit;
    logic             rep_end;

    assign load_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign sr_load    = load_ready && load_valid;
    assign sr_shift   = (state == ST_SHIFT) && !par_phase;
    // A repetition ends on bit 0, or on the parity cycle that follows it.
    assign rep_end    = PAR_EN ? par_phase : last_bit;

    seq_gen_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .shift    (sr_shift),
        .pat_in   (pat_in),
        .bit_cur  (bit_cur),
        .next_bit (next_bit),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            done      <= 1'b0;
            rep_cnt   <= '0;
            par_bit   <= 1'b0;
            par_phase <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    if (load_valid) begin
                        rep_cnt   <= rep_in;
                        par_bit   <= ^pat_in;
                        par_phase <= 1'b0;
                        if (rep_in == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_SHIFT;
                            x       <= pat_in[PAT_W-1];
                            x_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        x         <= 1'b0;
                        x_valid   <= 1'b0;
                        par_phase <= 1'b0;
                    end else if (rep_end) begin
                        rep_cnt   <= rep_cnt - CNT_W'(1);
                        par_phase <= 1'b0;
                        if (rep_cnt == CNT_W'(1)) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            x       <= 1'b0;
                            x_valid <= 1'b0;
                        end else begin
                            // After the parity cycle the index has already wrapped to the MSB.
                            x <= PAR_EN ? bit_cur : next_bit;
                        end
                    end else if (PAR_EN && last_bit) begin
                        par_phase <= 1'b1;
                        x         <= par_bit;
                    end else begin
                        x <= next_bit;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_serial.sv
// Bench for seq_gen_serial: directed and random jobs compared against a bit-stream model.
module tb_seq_gen_serial;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] rep_in;
    logic             stop;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_q[$];

    seq_gen_serial #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .pat_in     (pat_in),
        .rep_in     (rep_in),
        .stop       (stop),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial stream: pattern bits MSB-first per repetition, plus parity when enabled.
    task automatic build_model(input int pat, input int rep);
        bit b;
        bit par;
        exp_q.delete();
        for (int r = 0; r < rep; r++) begin
            par = 1'b0;
            for (int k = PAT_W - 1; k >= 0; k--) begin
                b = ((pat >> k) % 2) == 1;
                exp_q.push_back(b);
                par = par ^ b;
            end
`ifdef SEQ_GEN_PARITY_EN
            exp_q.push_back(par);
`endif
        end
    endtask

    task automatic run_job(input int pat, input int rep, input int stop_at, input bit stop_on_accept);
        int waited = 0;
        int nbits;
        bit stopped;
        while (!load_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("ready_before_load", load_ready, 1'b1);
        pat_in     = PAT_W'(pat);
        rep_in     = CNT_W'(rep);
        load_valid = 1'b1;
        stop       = stop_on_accept;
        tick();
        load_valid = 1'b0;
        stop       = 1'b0;
        pat_in     = PAT_W'($urandom);
        rep_in     = CNT_W'($urandom);
        build_model(pat, rep);
        stopped = (stop_at > 0) && (stop_at <= exp_q.size());
        nbits   = stopped ? stop_at : exp_q.size();
        for (int i = 0; i < nbits; i++) begin
            check("x_valid_bit", x_valid, 1'b1);
            check("x_bit", x, exp_q[i]);
            check("busy_bit", busy, 1'b1);
            check("ready_bit", load_ready, 1'b0);
            check("done_bit", done, 1'b0);
            if (stopped && i == nbits - 1) stop = 1'b1;
            load_valid = $urandom_range(0, 1) == 1;
            tick();
            stop       = 1'b0;
            load_valid = 1'b0;
        end
        if (stopped) begin
            check("stop_x_valid", x_valid, 1'b0);
            check("stop_done", done, 1'b0);
            check("stop_ready", load_ready, 1'b1);
        end else begin
            check("done_pulse", done, 1'b1);
            check("done_x_valid", x_valid, 1'b0);
            check("done_x", x, 1'b0);
            check("done_ready", load_ready, 1'b0);
            check("done_busy", busy, 1'b1);
            stop = $urandom_range(0, 1) == 1;
            tick();
            stop = 1'b0;
            check("after_done", done, 1'b0);
            check("after_ready", load_ready, 1'b1);
            check("after_busy", busy, 1'b0);
            check("after_x_valid", x_valid, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b1;
        stop       = 1'b0;
        pat_in     = 4'b1010;
        rep_in     = 8'd1;
        tick();
        tick();
        check("rst_x", x, 1'b0);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", load_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst        = 1'b0;
        load_valid = 1'b0;
        tick();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_x_valid", x_valid, 1'b0);

        run_job(4'b1010, 1, 0, 1'b0);
        run_job(4'b1010, 3, 0, 1'b0);
        run_job(4'b0111, 0, 0, 1'b0);
        run_job(4'b1101, 2, 3, 1'b0);
        run_job(4'b1011, 2, 0, 1'b0);
        run_job(4'b1010, 1, 0, 1'b1);
        run_job(4'b1001, 2, 8, 1'b0);
        run_job(4'b0110, 255, 0, 1'b0);

        // Reset in the middle of a job returns straight to idle.
        pat_in     = 4'b1111;
        rep_in     = 8'd4;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_x_valid", x_valid, 1'b0);
        check("midrst_x", x, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready", load_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);

        for (int j = 0; j < 30; j++) begin
            run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0,
                    $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
